// File: rtl/shape_vertex_gen_pkg.sv
// Shared types and local-vertex tables for the tangram vertex generator.
// Fixed-point widths mirror the project-wide constants header.
package shape_vertex_gen_pkg;

   localparam int INT_BITS       = 16;
   localparam int FLOAT_BITS     = 16;
   localparam int FLOAT_DCM_BITS = 14;
   localparam int LOC_W          = INT_BITS + 1;

   typedef enum logic [1:0] {TRI = 2'd0, SQUARE = 2'd1, PARA = 2'd2} shape_ty_e;
   typedef enum logic [1:0] {IDLE, ROT, EMIT, BBOX} svg_state_e;

   typedef struct packed {
      logic signed [LOC_W-1:0] u;
      logic signed [LOC_W-1:0] v;
   } local_vtx_t;

   function automatic logic [2:0] vtx_count(input shape_ty_e t);
      return (t == TRI) ? 3'd3 : 3'd4;
   endfunction

   // Local corners in emit order; one extra bit keeps -S representable for the parallelogram.
   function automatic local_vtx_t vtx_local(input shape_ty_e t, input logic [1:0] idx,
                                            input logic [INT_BITS-1:0] size);
      logic signed [LOC_W-1:0] s;
      local_vtx_t lv;
      s    = $signed({1'b0, size});
      lv.u = '0;
      lv.v = '0;
      case (idx)
         2'd1: lv.u = s;
         2'd2: begin
            if (t == SQUARE) lv.u = s;
            lv.v = s;
         end
         2'd3: begin
            if (t == PARA) lv.u = -s;
            lv.v = s;
         end
         default: ;
      endcase
      return lv;
   endfunction

endpackage

// File: rtl/vertex_rotate_fwd.sv
// Local->screen rotation: dx = floor(u*cos - v*sin), dy = floor(u*sin + v*cos) in pixels.
// STAGES-deep registered pipeline; the result is kept modulo 2^OUT_W since callers wrap anyway.
module vertex_rotate_fwd #(
   parameter int DATA_W = 17,
   parameter int COEF_W = 16,
   parameter int FRAC   = 14,
   parameter int OUT_W  = 16,
   parameter int STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vld_in,
   input  logic signed [DATA_W-1:0] u,
   input  logic signed [DATA_W-1:0] v,
   input  logic signed [COEF_W-1:0] sn,
   input  logic signed [COEF_W-1:0] cs,
   output logic                     vld_out,
   output logic signed [OUT_W-1:0]  dx,
   output logic signed [OUT_W-1:0]  dy
);

   localparam int PW = DATA_W + COEF_W + 1;

   function automatic logic signed [OUT_W-1:0] floor_wrap(input logic signed [PW-1:0] a);
      logic signed [PW-1:0] sh;
      sh = a >>> FRAC;
      return sh[OUT_W-1:0];
   endfunction

   logic signed [PW-1:0] dx_sum, dy_sum;
   logic signed [OUT_W-1:0] dx_p [STAGES];
   logic signed [OUT_W-1:0] dy_p [STAGES];
   logic [STAGES-1:0] vld_p;

   always_comb begin
      dx_sum = PW'(u) * PW'(cs) - PW'(v) * PW'(sn);
      dy_sum = PW'(u) * PW'(sn) + PW'(v) * PW'(cs);
   end

   // p0: multiply-add result; p1..: delay to the configured latency
   always_ff @(posedge clk) begin
      dx_p[0] <= floor_wrap(dx_sum);
      dy_p[0] <= floor_wrap(dy_sum);
      for (int i = 1; i < STAGES; i++) begin
         dx_p[i] <= dx_p[i-1];
         dy_p[i] <= dy_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= vld_in;
         for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   assign vld_out = vld_p[STAGES-1];
   assign dx      = dx_p[STAGES-1];
   assign dy      = dy_p[STAGES-1];

endmodule

// File: rtl/shape_vertex_gen.sv
// Streams the screen-space corners of one tangram piece, then pulses its bounding box.
// The first vertex is launched into the rotate pipe in the accept cycle to meet N+1+ROT_LAT.
module shape_vertex_gen
   import shape_vertex_gen_pkg::*;
#(
   parameter int ROT_LAT = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INT_BITS-1:0]          ty,
   input  logic signed [INT_BITS-1:0]   x0,
   input  logic signed [INT_BITS-1:0]   y0,
   input  logic [INT_BITS-1:0]          size,
   input  logic signed [FLOAT_BITS-1:0] sin,
   input  logic signed [FLOAT_BITS-1:0] cos,
   output logic                         vtx_valid,
   input  logic                         vtx_ready,
   output logic signed [INT_BITS-1:0]   vtx_x,
   output logic signed [INT_BITS-1:0]   vtx_y,
   output logic [1:0]                   vtx_idx,
   output logic                         vtx_last,
   output logic                         bbox_valid,
   output logic signed [INT_BITS-1:0]   bbox_xmin,
   output logic signed [INT_BITS-1:0]   bbox_xmax,
   output logic signed [INT_BITS-1:0]   bbox_ymin,
   output logic signed [INT_BITS-1:0]   bbox_ymax,
   output logic                         err
);

   svg_state_e state;
   shape_ty_e ty_r;
   logic signed [INT_BITS-1:0] x0_r, y0_r;
   logic [INT_BITS-1:0] size_r;
   logic signed [FLOAT_BITS-1:0] sin_r, cos_r;

   logic in_idle, ty_ok, rot_vld_in, rot_vld;
   logic [1:0] src_idx;
   local_vtx_t lv;
   logic signed [FLOAT_BITS-1:0] rot_sin, rot_cos;
   logic signed [INT_BITS-1:0] dx, dy, vx, vy;

   assign in_idle  = (state == IDLE);
   assign in_ready = in_idle;
   assign ty_ok    = (ty <= INT_BITS'(2));

   // While idle the pipe is fed straight from the ports so vertex 0 starts in the accept cycle.
   always_comb begin
      src_idx    = in_idle ? 2'd0 : vtx_idx + 2'd1;
      lv         = vtx_local(in_idle ? shape_ty_e'(ty[1:0]) : ty_r, src_idx,
                             in_idle ? size : size_r);
      rot_sin    = in_idle ? sin : sin_r;
      rot_cos    = in_idle ? cos : cos_r;
      rot_vld_in = (in_idle && in_valid && ty_ok) ||
                   (state == EMIT && vtx_ready && !vtx_last);
      vx         = x0_r + dx;
      vy         = y0_r + dy;
   end

   vertex_rotate_fwd #(
      .DATA_W(LOC_W),
      .COEF_W(FLOAT_BITS),
      .FRAC  (FLOAT_DCM_BITS),
      .OUT_W (INT_BITS),
      .STAGES(ROT_LAT)
   ) u_rot (
      .clk    (clk),
      .rst    (rst),
      .vld_in (rot_vld_in),
      .u      (lv.u),
      .v      (lv.v),
      .sn     (rot_sin),
      .cs     (rot_cos),
      .vld_out(rot_vld),
      .dx     (dx),
      .dy     (dy)
   );

   always_ff @(posedge clk) begin
      if (in_idle && in_valid) begin
         ty_r   <= shape_ty_e'(ty[1:0]);
         x0_r   <= x0;
         y0_r   <= y0;
         size_r <= size;
         sin_r  <= sin;
         cos_r  <= cos;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vtx_valid  <= 1'b0;
         vtx_x      <= '0;
         vtx_y      <= '0;
         vtx_idx    <= '0;
         vtx_last   <= 1'b0;
         bbox_valid <= 1'b0;
         bbox_xmin  <= '0;
         bbox_xmax  <= '0;
         bbox_ymin  <= '0;
         bbox_ymax  <= '0;
         err        <= 1'b0;
      end else begin
         err        <= 1'b0;
         bbox_valid <= 1'b0;
         case (state)
            IDLE: if (in_valid) begin
               if (ty_ok) begin
                  vtx_idx <= 2'd0;
                  state   <= ROT;
               end else begin
                  err <= 1'b1;
               end
            end
            ROT: if (rot_vld) begin
               vtx_valid <= 1'b1;
               vtx_x     <= vx;
               vtx_y     <= vy;
               vtx_last  <= ({1'b0, vtx_idx} == vtx_count(ty_r) - 3'd1);
               state     <= EMIT;
            end
            EMIT: if (vtx_ready) begin
               vtx_valid <= 1'b0;
               vtx_last  <= 1'b0;
               // Vertex 0 seeds the extents so an all-negative shape is not clamped to 0.
               if (vtx_idx == 2'd0) begin
                  bbox_xmin <= vtx_x;
                  bbox_xmax <= vtx_x;
                  bbox_ymin <= vtx_y;
                  bbox_ymax <= vtx_y;
               end else begin
                  if (vtx_x < bbox_xmin) bbox_xmin <= vtx_x;
                  if (vtx_x > bbox_xmax) bbox_xmax <= vtx_x;
                  if (vtx_y < bbox_ymin) bbox_ymin <= vtx_y;
                  if (vtx_y > bbox_ymax) bbox_ymax <= vtx_y;
               end
               if (vtx_last) begin
                  bbox_valid <= 1'b1;
                  state      <= BBOX;
               end else begin
                  vtx_idx <= vtx_idx + 2'd1;
                  state   <= ROT;
               end
            end
            BBOX: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shape_vertex_gen.sv
// Randomized bench for shape_vertex_gen against a plain-arithmetic corner/extent model.
module tb_shape_vertex_gen;
   import shape_vertex_gen_pkg::*;

   localparam int ROT_LAT = 2;
   localparam int ONE     = 1 << FLOAT_DCM_BITS;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, vtx_valid, vtx_ready, vtx_last, bbox_valid, err;
   logic [INT_BITS-1:0] ty_i, sz;
   logic signed [INT_BITS-1:0] x0_i, y0_i, vtx_x, vtx_y;
   logic signed [INT_BITS-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
   logic signed [FLOAT_BITS-1:0] sn, cs;
   logic [1:0] vtx_idx;

   int n_chk = 0;
   int n_err = 0;

   shape_vertex_gen #(.ROT_LAT(ROT_LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ty(ty_i), .x0(x0_i), .y0(y0_i), .size(sz), .sin(sn), .cos(cs),
      .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_x(vtx_x), .vtx_y(vtx_y),
      .vtx_idx(vtx_idx), .vtx_last(vtx_last), .bbox_valid(bbox_valid),
      .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin),
      .bbox_ymax(bbox_ymax), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrap(input longint a);
      logic signed [INT_BITS-1:0] t;
      t = a[INT_BITS-1:0];
      return longint'(t);
   endfunction

   // Screen-space corner k of a piece: anchor + floor(rotated local corner), wrapped.
   function automatic void model_vtx(input int t, input int k, input longint x0, input longint y0,
                                     input longint s, input longint sv, input longint cv,
                                     output longint ex, output longint ey);
      int ut [3][4] = '{'{0, 1, 0, 0}, '{0, 1, 1, 0}, '{0, 1, 0, -1}};
      int vt [3][4] = '{'{0, 0, 1, 0}, '{0, 0, 1, 1}, '{0, 0, 1, 1}};
      longint u, v;
      u  = ut[t][k] * s;
      v  = vt[t][k] * s;
      ex = wrap(x0 + ((u * cv - v * sv) >>> FLOAT_DCM_BITS));
      ey = wrap(y0 + ((u * sv + v * cv) >>> FLOAT_DCM_BITS));
   endfunction

   // Inverse map of a screen pixel into the piece's local square [0,S]x[0,S].
   function automatic logic inside_sq(input longint px, input longint py, input longint x0,
                                      input longint y0, input longint s, input longint sv,
                                      input longint cv);
      longint u, v, lim;
      u   = (px - x0) * cv + (py - y0) * sv;
      v   = (py - y0) * cv - (px - x0) * sv;
      lim = s * ONE;
      return (u >= 0) && (v >= 0) && (u <= lim) && (v <= lim);
   endfunction

   function automatic longint sgn(input longint a);
      return (a > 0) ? 1 : (a < 0) ? -1 : 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_shape(input int t, input longint x0, input longint y0, input longint s,
                            input longint sv, input longint cv, input int stall_idx,
                            input int stall_n, input int abort_idx, input bit incl);
      longint ex [4];
      longint ey [4];
      longint xmin, xmax, ymin, ymax, sx, sy;
      int nv, cnt;
      nv = (t == 0) ? 3 : 4;
      sx = 0;
      sy = 0;
      for (int k = 0; k < nv; k++) begin
         model_vtx(t, k, x0, y0, s, sv, cv, ex[k], ey[k]);
         sx += ex[k];
         sy += ey[k];
      end
      xmin = ex[0]; xmax = ex[0]; ymin = ey[0]; ymax = ey[0];
      for (int k = 1; k < nv; k++) begin
         if (ex[k] < xmin) xmin = ex[k];
         if (ex[k] > xmax) xmax = ex[k];
         if (ey[k] < ymin) ymin = ey[k];
         if (ey[k] > ymax) ymax = ey[k];
      end

      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      ty_i = INT_BITS'(t);
      x0_i = x0[INT_BITS-1:0];
      y0_i = y0[INT_BITS-1:0];
      sz   = s[INT_BITS-1:0];
      sn   = sv[FLOAT_BITS-1:0];
      cs   = cv[FLOAT_BITS-1:0];
      step();
      in_valid = 1'b0;
      ty_i = INT_BITS'($urandom);
      x0_i = INT_BITS'($urandom);
      y0_i = INT_BITS'($urandom);
      sz   = INT_BITS'($urandom);
      sn   = FLOAT_BITS'($urandom);
      cs   = FLOAT_BITS'($urandom);

      for (int k = 0; k < nv; k++) begin
         cnt = 1;
         while (!vtx_valid && cnt < 40) begin
            step();
            cnt++;
         end
         check("vtx_latency", cnt, 1 + ROT_LAT);
         if (!vtx_valid) return;
         check("vtx_x", vtx_x, ex[k]);
         check("vtx_y", vtx_y, ey[k]);
         check("vtx_idx", vtx_idx, k);
         check("vtx_last", vtx_last, (k == nv - 1));
         check("in_ready_busy", in_ready, 0);
         if (incl)
            check("inclusion", inside_sq(longint'(vtx_x) + sgn(sx - nv * ex[k]),
                                         longint'(vtx_y) + sgn(sy - nv * ey[k]),
                                         x0, y0, s, sv, cv), 1);
         if (k == abort_idx) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            check("rst_vtx_valid", vtx_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_bbox_valid", bbox_valid, 0);
            for (int i = 0; i < ROT_LAT + 3; i++) begin
               step();
               check("rst_no_bbox", bbox_valid, 0);
               check("rst_no_vtx", vtx_valid, 0);
            end
            return;
         end
         if (k == stall_idx) begin
            for (int i = 0; i < stall_n; i++) begin
               step();
               check("hold_valid", vtx_valid, 1);
               check("hold_x", vtx_x, ex[k]);
               check("hold_y", vtx_y, ey[k]);
               check("hold_idx", vtx_idx, k);
            end
         end
         vtx_ready = 1'b1;
         step();
         vtx_ready = 1'b0;
         if (k < nv - 1) check("vtx_drop", vtx_valid, 0);
      end

      check("bbox_valid", bbox_valid, 1);
      check("bbox_xmin", bbox_xmin, xmin);
      check("bbox_xmax", bbox_xmax, xmax);
      check("bbox_ymin", bbox_ymin, ymin);
      check("bbox_ymax", bbox_ymax, ymax);
      check("bbox_in_ready", in_ready, 0);
      step();
      check("bbox_pulse", bbox_valid, 0);
      check("in_ready_after", in_ready, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, st_idx, st_n;
      longint x0, y0, s, sv, cv;
      rst = 1'b1;
      in_valid = 1'b0;
      vtx_ready = 1'b0;
      ty_i = '0; x0_i = '0; y0_i = '0; sz = '0; sn = '0; cs = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_vtx_valid", vtx_valid, 0);
      check("rst_vtx_x", vtx_x, 0);
      check("rst_vtx_last", vtx_last, 0);
      check("rst_bbox_valid", bbox_valid, 0);
      check("rst_bbox_xmin", bbox_xmin, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      step();

      run_shape(1, 100, 50, 10, 0, ONE, 4, 0, 4, 0);
      run_shape(0, 20, 20, 8, ONE, 0, 4, 0, 4, 0);
      run_shape(2, 0, 0, 5, 0, ONE, 4, 0, 4, 0);
      run_shape(1, 200, 100, 20, 11585, 11585, 4, 0, 4, 1);
      run_shape(1, 32760, -32760, 20, 0, ONE, 1, 5, 4, 0);

      in_valid = 1'b1;
      ty_i = INT_BITS'(3);
      step();
      in_valid = 1'b0;
      check("err_pulse", err, 1);
      check("err_in_ready", in_ready, 1);
      check("err_no_vtx", vtx_valid, 0);
      for (int i = 0; i < ROT_LAT + 3; i++) begin
         step();
         check("err_once", err, 0);
         check("err_no_vtx_later", vtx_valid, 0);
      end

      run_shape(2, -7, 13, 9, 0, ONE, 4, 0, 4, 0);
      run_shape(1, 100, 50, 10, 0, ONE, 4, 0, 2, 0);
      run_shape(0, 30, -40, 6, -ONE, 0, 4, 0, 4, 0);

      for (int n = 0; n < 12; n++) begin
         t      = int'($urandom_range(0, 2));
         x0     = longint'($urandom_range(0, 4000)) - 2000;
         y0     = longint'($urandom_range(0, 4000)) - 2000;
         s      = longint'($urandom_range(0, 300));
         sv     = longint'($urandom_range(0, 2 * ONE)) - ONE;
         cv     = longint'($urandom_range(0, 2 * ONE)) - ONE;
         st_idx = int'($urandom_range(0, 3));
         st_n   = int'($urandom_range(0, 4));
         run_shape(t, x0, y0, s, sv, cv, st_idx, st_n, 4, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
